// File: rtl/alu_sequencer.sv
// alu_sequencer: feeds a shared combinational ALU from a byte stream.
// It collects operand A, operand B and the opcode as three bytes, then drives
// the ALU inputs and waits a fixed number of cycles. It captures alu_result and
// offers it on a valid/ready byte sink.
// Ports:
//   clk, btn_Reset (async, active-low)
//   rx_data/rx_valid/rx_ready        : incoming byte stream
//   alu_A/alu_B/alu_op, alu_result   : shared ALU interface
//   tx_data/tx_valid/tx_ready        : result byte sink
//   busy, op_error, timeout, op_count: status
module alu_sequencer #(
    parameter int unsigned NBITS       = 8,
    parameter int unsigned COD_OP      = 6,
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned TIMEOUT     = 1000000
) (
    input  logic              clk,
    input  logic              btn_Reset,
    input  logic [NBITS-1:0]  rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [NBITS-1:0]  alu_A,
    output logic [NBITS-1:0]  alu_B,
    output logic [COD_OP-1:0] alu_op,
    input  logic [NBITS-1:0]  alu_result,
    output logic [NBITS-1:0]  tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              op_error,
    output logic              timeout,
    output logic [7:0]        op_count
);

    localparam int unsigned CW = $clog2(EXEC_CYCLES + 1);
    localparam int unsigned IW = $clog2(TIMEOUT);

    localparam logic [COD_OP-1:0] OP_ADD = COD_OP'(6'b100000);
    localparam logic [COD_OP-1:0] OP_SUB = COD_OP'(6'b100010);
    localparam logic [COD_OP-1:0] OP_AND = COD_OP'(6'b100100);
    localparam logic [COD_OP-1:0] OP_OR  = COD_OP'(6'b100101);
    localparam logic [COD_OP-1:0] OP_XOR = COD_OP'(6'b100110);
    localparam logic [COD_OP-1:0] OP_NOR = COD_OP'(6'b100111);
    localparam logic [COD_OP-1:0] OP_SRA = COD_OP'(6'b000011);
    localparam logic [COD_OP-1:0] OP_SRL = COD_OP'(6'b000010);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND
    } state_t;

    state_t            state_q, state_d;
    logic [NBITS-1:0]  alu_a_q, alu_a_d;
    logic [NBITS-1:0]  alu_b_q, alu_b_d;
    logic [COD_OP-1:0] alu_op_q, alu_op_d;
    logic [NBITS-1:0]  tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              rx_ready_q, rx_ready_d;
    logic              busy_q, busy_d;
    logic              op_error_q, op_error_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        op_count_q, op_count_d;
    logic [CW-1:0]     exec_cnt_q, exec_cnt_d;
    logic [IW-1:0]     idle_q, idle_d;

    logic              accept;
    logic [COD_OP-1:0] rx_opcode;
    logic              opcode_ok;
    logic              idle_expired;

    assign accept       = rx_valid && rx_ready_q;
    assign rx_opcode    = rx_data[COD_OP-1:0];
    assign idle_expired = (idle_q == IW'(TIMEOUT - 1));

    always_comb begin
        case (rx_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: opcode_ok = 1'b1;
            default:                        opcode_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        op_count_d = op_count_q;
        exec_cnt_d = exec_cnt_q;
        idle_d     = idle_q;
        op_error_d = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            WAIT_A: begin
                if (accept) begin
                    alu_a_d = rx_data;
                    idle_d  = '0;
                    state_d = WAIT_B;
                end
            end
            WAIT_B, WAIT_OP: begin
                // An accept on the expiry cycle takes priority over the abort.
                if (accept) begin
                    idle_d = '0;
                    if (state_q == WAIT_B) begin
                        alu_b_d = rx_data;
                        state_d = WAIT_OP;
                    end else if (opcode_ok) begin
                        alu_op_d   = rx_opcode;
                        exec_cnt_d = CW'(EXEC_CYCLES);
                        state_d    = EXEC;
                    end else begin
                        op_error_d = 1'b1;
                        state_d    = WAIT_A;
                    end
                end else if (idle_expired) begin
                    timeout_d = 1'b1;
                    idle_d    = '0;
                    state_d   = WAIT_A;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            EXEC: begin
                // Capture happens on the cycle after the counter drains, so
                // tx_valid rises EXEC_CYCLES+1 cycles after the opcode accept.
                if (exec_cnt_q == '0) begin
                    tx_data_d  = alu_result;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end else begin
                    exec_cnt_d = exec_cnt_q - CW'(1);
                end
            end
            SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    op_count_d = op_count_q + 8'd1;
                    state_d    = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase

        rx_ready_d = (state_d == WAIT_A) || (state_d == WAIT_B) || (state_d == WAIT_OP);
        busy_d     = (state_d == EXEC) || (state_d == SEND);
    end

    always_ff @(posedge clk or negedge btn_Reset) begin
        if (!btn_Reset) begin
            state_q    <= WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            op_error_q <= 1'b0;
            timeout_q  <= 1'b0;
            op_count_q <= '0;
            exec_cnt_q <= '0;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            op_error_q <= op_error_d;
            timeout_q  <= timeout_d;
            op_count_q <= op_count_d;
            exec_cnt_q <= exec_cnt_d;
            idle_q     <= idle_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign alu_A    = alu_a_q;
    assign alu_B    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign op_error = op_error_q;
    assign timeout  = timeout_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer. It provides the ALU and
// keeps a transaction-level expectation of every output, compared each cycle.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       btn_Reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] alu_A, alu_B, alu_result, tx_data;
    logic [5:0] alu_op;
    logic       tx_valid, tx_ready, busy, op_error, timeout;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] e_A, e_B, e_tx_data, e_count;
    logic [5:0] e_op;
    logic       e_rx_ready, e_busy, e_tx_valid, e_op_error, e_timeout;

    logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

    always #5 clk = ~clk;

    alu_sequencer #(
        .NBITS(8), .COD_OP(6), .EXEC_CYCLES(1), .TIMEOUT(16)
    ) dut (
        .clk(clk), .btn_Reset(btn_Reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_result(alu_result),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .op_error(op_error), .timeout(timeout), .op_count(op_count)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h03: return 8'($signed(a) >>> b);
            6'h02: return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_A, alu_B, alu_op);

    function automatic bit is_valid(input logic [5:0] op);
        foreach (valid_ops[i]) if (valid_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rx_ready", 32'(rx_ready), 32'(e_rx_ready));
            check("busy", 32'(busy), 32'(e_busy));
            check("tx_valid", 32'(tx_valid), 32'(e_tx_valid));
            check("tx_data", 32'(tx_data), 32'(e_tx_data));
            check("alu_A", 32'(alu_A), 32'(e_A));
            check("alu_B", 32'(alu_B), 32'(e_B));
            check("alu_op", 32'(alu_op), 32'(e_op));
            check("op_count", 32'(op_count), 32'(e_count));
            check("op_error", 32'(op_error), 32'(e_op_error));
            check("timeout", 32'(timeout), 32'(e_timeout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_reset();
        e_A = 8'h00; e_B = 8'h00; e_op = 6'h00; e_tx_data = 8'h00; e_count = 8'h00;
        e_rx_ready = 1'b0; e_busy = 1'b0; e_tx_valid = 1'b0;
        e_op_error = 1'b0; e_timeout = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // One full A/B/opcode transaction from WAIT_A; hold = cycles tx_ready stays low in SEND.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int hold, input bit tie);
        if (tie) tx_ready = 1'b1;
        send_byte(a); e_A = a;
        send_byte(b); e_B = b;
        send_byte(op);
        if (is_valid(op[5:0])) begin
            e_op = op[5:0]; e_rx_ready = 1'b0; e_busy = 1'b1;
            tick();
            tick();
            e_tx_valid = 1'b1;
            e_tx_data  = alu_f(a, b, op[5:0]);
            for (int i = 0; i < hold; i++) begin
                rx_valid = 1'b1;
                rx_data  = 8'hAA;
                tick();
            end
            rx_valid = 1'b0;
            tx_ready = 1'b1;
            tick();
            e_tx_valid = 1'b0; e_busy = 1'b0; e_rx_ready = 1'b1; e_count = e_count + 8'd1;
            if (!tie) tx_ready = 1'b0;
        end else begin
            e_op_error = 1'b1;
            tick();
            e_op_error = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        btn_Reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        expect_reset();
        #1;
        chk_en = 1'b1;
        tick();
        tick();
        btn_Reset = 1'b1;
        check("rx_ready_before_edge", 32'(rx_ready), 32'd0);
        tick();
        e_rx_ready = 1'b1;
        check("rx_ready_after_release", 32'(rx_ready), 32'd1);

        // Invalid opcode straight after reset: alu_op must remain 0.
        do_op(8'h01, 8'h02, 8'h3F, 0, 1'b0);
        check("invalid_alu_op", 32'(alu_op), 32'h00);
        check("invalid_count", 32'(op_count), 32'h00);

        do_op(8'h05, 8'h03, 8'h20, 0, 1'b0);
        check("add_result", 32'(tx_data), 32'h08);
        check("add_count", 32'(op_count), 32'h01);

        do_op(8'hF0, 8'h0F, 8'h26, 10, 1'b0);
        check("xor_result", 32'(tx_data), 32'hFF);

        // Silence after A: abort 16 edges after the A accept.
        send_byte(8'h11); e_A = 8'h11;
        repeat (15) tick();
        tick(); e_timeout = 1'b1;
        tick(); e_timeout = 1'b0;
        do_op(8'h22, 8'h03, 8'h22, 0, 1'b0);
        check("after_timeout_A", 32'(alu_A), 32'h22);
        check("after_timeout_res", 32'(tx_data), 32'h1F);

        // Accept on the expiry cycle wins; then silence in WAIT_OP aborts.
        send_byte(8'h33); e_A = 8'h33;
        repeat (15) tick();
        send_byte(8'h44); e_B = 8'h44;
        repeat (15) tick();
        tick(); e_timeout = 1'b1;
        tick(); e_timeout = 1'b0;

        do_op(8'h81, 8'h02, 8'h03, 0, 1'b0);
        check("sra_result", 32'(tx_data), 32'hE0);

        // Async reset while SEND holds tx_valid.
        send_byte(8'h5A); e_A = 8'h5A;
        send_byte(8'h11); e_B = 8'h11;
        send_byte(8'h20); e_op = 6'h20; e_rx_ready = 1'b0; e_busy = 1'b1;
        tick();
        tick(); e_tx_valid = 1'b1; e_tx_data = 8'h6B;
        tick();
        check("pre_reset_valid", 32'(tx_valid), 32'd1);
        #2;
        btn_Reset = 1'b0;
        expect_reset();
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_alu_A", 32'(alu_A), 32'd0);
        check("rst_alu_B", 32'(alu_B), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        tick();
        btn_Reset = 1'b1;
        tick();
        e_rx_ready = 1'b1;
        check("rst_rx_ready", 32'(rx_ready), 32'd1);

        // 256 SUBs back-to-back with tx_ready tied high; one with junk upper opcode bits.
        for (int i = 0; i < 256; i++) begin
            do_op(8'(i), 8'(i * 37 + 5), (i == 100) ? 8'hE2 : 8'h22, 0, 1'b1);
        end
        tx_ready = 1'b0;
        check("wrap_count", 32'(op_count), 32'h00);
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
